// File: rtl/act_pkg.sv
// Shared definitions for the piecewise-linear activation pipeline.
//   act_mode_e     : selects sigmoid or tanh for a transaction
//   act_gen_table  : builds the 9-entry sigmoid breakpoint table at elaboration
//   ACT_ONE        : fixed-point 1.0
//   ACT_SAT_BP     : |u| at or above this clamps to ONE (4.0)
//   act_pay_t      : payload carried through the S1/S2 registers
//   act_out_t      : payload of the output (S3) register
// Payload field widths follow the package defaults below. Any instance of
// act_pwl_pipe must use parameter values that match them.
package act_pkg;

  localparam int unsigned ACT_INT_WIDTH  = 8;
  localparam int unsigned ACT_FRAC_WIDTH = 8;
  localparam int unsigned ACT_WIDTH      = ACT_INT_WIDTH + ACT_FRAC_WIDTH + 1;
  localparam int unsigned ACT_TAG_WIDTH  = 4;
  localparam int unsigned ACT_NSEG       = 8;
  // S1 stores the segment offset f here and S2 replaces it with the slope
  // product p. p < d <= ONE, so FRAC+1 bits hold either value.
  localparam int unsigned ACT_FP_W       = ACT_FRAC_WIDTH + 1;

  localparam logic [ACT_WIDTH-1:0] ACT_ONE    = ACT_WIDTH'(1) << ACT_FRAC_WIDTH;
  localparam logic [ACT_WIDTH-1:0] ACT_SAT_BP = ACT_WIDTH'(4) << ACT_FRAC_WIDTH;

  typedef enum logic {
    ACT_SIGMOID = 1'b0,
    ACT_TANH    = 1'b1
  } act_mode_e;

  typedef logic [ACT_NSEG:0][ACT_WIDTH-1:0] act_tbl_t;

  // e^v by Taylor series. This is only evaluated at elaboration, for |v| <= 4,
  // where 40 terms are far more than enough.
  function automatic real act_exp(input real v);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int unsigned n = 1; n < 40; n++) begin
      term = term * v / real'(n);
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Y[j] = round(sigmoid(j * 0.5) * 2^frac), j = 0..8
  function automatic act_tbl_t act_gen_table(input int unsigned frac);
    act_tbl_t t;
    real      one;
    real      sig;
    one = 1.0;
    for (int unsigned i = 0; i < frac; i++) begin
      one = one * 2.0;
    end
    for (int unsigned j = 0; j <= ACT_NSEG; j++) begin
      sig  = 1.0 / (1.0 + act_exp(-0.5 * real'(j)));
      t[j] = ACT_WIDTH'($rtoi(sig * one + 0.5));
    end
    return t;
  endfunction

  typedef struct packed {
    logic                     valid;
    act_mode_e                mode;
    logic                     neg;
    logic                     sat;
    logic [2:0]               k;
    logic [ACT_FP_W-1:0]      fp;
    logic [ACT_TAG_WIDTH-1:0] tag;
  } act_pay_t;

  typedef struct packed {
    logic [ACT_WIDTH-1:0]     y;
    logic [ACT_TAG_WIDTH-1:0] tag;
  } act_out_t;

endpackage

// File: rtl/act_pwl_stage_ctrl.sv
// Generic valid/ready register slice. One instance holds one pipeline stage.
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : upstream offers in_data
//   in_ready   : slice accepts this cycle (empty, or its content drains now)
//   in_data    : payload to capture
//   out_valid  : slice holds a payload
//   out_ready  : downstream takes out_data this cycle
//   out_data   : held payload, stable while out_valid && !out_ready
// in_ready depends only on the slice state, out_ready and reset, never on
// in_valid. Payload storage is reset too, so outputs read zero after reset.
module act_pwl_stage_ctrl #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic load;

  assign in_ready = !reset && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready) begin
        out_valid <= in_valid;
      end
      if (load) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/act_pwl_pipe.sv
// Three-stage, handshaked PWL activation unit (sigmoid / tanh).
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : input sample valid
//   in_ready   : unit can accept a sample this cycle
//   in_x       : signed fixed-point operand (FRAC_WIDTH fractional bits)
//   in_mode    : 0 = sigmoid, 1 = tanh
//   in_tag     : sideband, returned unchanged with the result
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   out_y      : signed fixed-point result
//   out_tag    : tag of the result
// S1: prescale and segment select. S2: slope multiply. S3: reconstruct.
// tanh(x) is computed as 2*sigmoid(2x) - 1.
module act_pwl_pipe
  import act_pkg::*;
#(
  parameter int INT_WIDTH  = ACT_INT_WIDTH,
  parameter int FRAC_WIDTH = ACT_FRAC_WIDTH,
  parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int TAG_WIDTH  = ACT_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic                    in_mode,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_y,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int unsigned PROD_W = WIDTH + ACT_FP_W;
  localparam logic signed [WIDTH-1:0] XMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] XMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam act_tbl_t Y = act_gen_table(FRAC_WIDTH);

  act_pay_t s1_d, s1_q, s2_d, s2_q;
  act_out_t s3_d, s3_q;
  logic     s1_vld, s2_vld, s3_vld;
  logic     s2_rdy, s3_rdy;

  // S1: u = x or sat(2x), then magnitude, sign, saturation and segment.
  logic signed [WIDTH-1:0] u1;
  logic [WIDTH-1:0]        a1;

  always_comb begin
    u1 = in_x;
    if (in_mode == ACT_TANH) begin
      // 2x overflows exactly when the top two bits differ
      if (in_x[WIDTH-1] != in_x[WIDTH-2]) begin
        u1 = in_x[WIDTH-1] ? XMIN : XMAX;
      end else begin
        u1 = in_x <<< 1;
      end
    end

    // -XMIN is not representable; its magnitude saturates to XMAX
    if (u1 == XMIN) begin
      a1 = XMAX;
    end else if (u1[WIDTH-1]) begin
      a1 = -u1;
    end else begin
      a1 = u1;
    end

    s1_d       = '0;
    s1_d.valid = 1'b1;
    s1_d.mode  = act_mode_e'(in_mode);
    s1_d.neg   = u1[WIDTH-1];
    s1_d.sat   = (a1 >= ACT_SAT_BP);
    s1_d.k     = a1[FRAC_WIDTH+1 -: 3];
    s1_d.fp    = ACT_FP_W'(a1[FRAC_WIDTH-2:0]);
    s1_d.tag   = in_tag;
  end

  act_pwl_stage_ctrl #(.T(act_pay_t)) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_vld),
    .out_ready (s2_rdy),
    .out_data  (s1_q)
  );

  // S2: p = ((Y[k+1] - Y[k]) * f) >> (FRAC-1), truncated. f is replaced by p.
  logic [3:0]        k2_lo, k2_hi;
  logic [WIDTH-1:0]  d2;
  logic [PROD_W-1:0] prod2;

  always_comb begin
    k2_lo   = {1'b0, s1_q.k};
    k2_hi   = k2_lo + 4'd1;
    d2      = Y[k2_hi] - Y[k2_lo];
    prod2   = PROD_W'(d2) * PROD_W'(s1_q.fp);
    s2_d    = s1_q;
    s2_d.fp = ACT_FP_W'(prod2 >> (FRAC_WIDTH - 1));
  end

  act_pwl_stage_ctrl #(.T(act_pay_t)) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_vld && s1_q.valid),
    .in_ready  (s2_rdy),
    .in_data   (s2_d),
    .out_valid (s2_vld),
    .out_ready (s3_rdy),
    .out_data  (s2_q)
  );

  // S3: s = sat ? ONE : Y[k] + p; mirror for negative u; tanh maps to 2s - ONE.
  logic [WIDTH-1:0] s3v;

  always_comb begin
    if (s2_q.sat) begin
      s3v = ACT_ONE;
    end else begin
      s3v = Y[{1'b0, s2_q.k}] + WIDTH'(s2_q.fp);
    end
    if (s2_q.neg) begin
      s3v = ACT_ONE - s3v;
    end
    s3_d.y   = (s2_q.mode == ACT_TANH) ? ((s3v << 1) - ACT_ONE) : s3v;
    s3_d.tag = s2_q.tag;
  end

  act_pwl_stage_ctrl #(.T(act_out_t)) u_s3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s2_vld && s2_q.valid),
    .in_ready  (s3_rdy),
    .in_data   (s3_d),
    .out_valid (s3_vld),
    .out_ready (out_ready),
    .out_data  (s3_q)
  );

  // Outputs read zero within the reset cycle itself, not only after it.
  assign out_valid = s3_vld && !reset;
  assign out_y     = reset ? '0 : s3_q.y;
  assign out_tag   = reset ? '0 : s3_q.tag;

endmodule

// File: tb/tb_act_pwl_pipe.sv
module tb_act_pwl_pipe;

  localparam int W  = 17;
  localparam int TW = 4;
  localparam int SW = 1100;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                in_valid  = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_x      = '0;
  logic                in_mode   = 1'b0;
  logic [TW-1:0]       in_tag    = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] out_y;
  logic [TW-1:0]       out_tag;

  act_pwl_pipe #(
    .INT_WIDTH  (8),
    .FRAC_WIDTH (8),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x;
    int y;
    int tag;
    int acc;
    bit lat;
    bit sw;
  } exp_t;

  exp_t sb[$];
  int   sw_y[0:2*SW];

  // Hand-computed vectors (FRAC=8, ONE=256); even = sigmoid, odd = tanh.
  int vx[16] = '{0, 0, 256, 128, -256, -768, 64, 65535,
                 192, 256, 512, -64, 1024, 512, -1024, -65536};
  bit vm[16] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int vy[16] = '{128, 0, 187, 118, 69, -256, 143, 256,
                 173, 194, 225, -62, 256, 256, 0, -256};

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Offer one sample from the next falling edge; push its expectation when
  // the handshake is seen; drop in_valid just after the accepting edge.
  task automatic send(input int x, input bit m, input int tag, input int y,
                      input bit lat, input bit sw, output int acc);
    exp_t e;
    int   waited;
    waited = 0;
    acc    = -1;
    @(negedge clk);
    in_x     = W'(x);
    in_mode  = m;
    in_tag   = TW'(tag);
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=0 for 50 cycles, expected 1 (tag %0d)", tag);
      in_valid = 1'b0;
    end else begin
      e.x   = x;
      e.y   = y;
      e.tag = tag;
      e.acc = cyc;
      e.lat = lat;
      e.sw  = sw;
      acc   = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string what);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_%s: %0d results outstanding, expected 0", what, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops and compares on every output handshake.
  initial begin : monitor
    exp_t                e;
    logic signed [W-1:0] py;
    logic [TW-1:0]       pt;
    bit                  pst;
    bit                  have_prev;
    int                  prev_sw;
    real                 ideal;
    real                 err;
    pst       = 1'b0;
    have_prev = 1'b0;
    prev_sw   = 0;
    py        = '0;
    pt        = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pst = 1'b0;
      end else begin
        if (pst) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_y", int'(out_y), int'(py));
          chk("hold_tag", int'(out_tag), int'(pt));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: y=%0d tag=%0d emitted, expected no output", out_y, out_tag);
          end else begin
            e = sb.pop_front();
            chk("tag", int'(out_tag), e.tag);
            if (e.lat) chk("latency", cyc - e.acc, 3);
            if (e.sw) begin
              ideal = 256.0 / (1.0 + $exp(-real'(e.x) / 256.0));
              err   = real'(int'(out_y)) - ideal;
              if (err < 0.0) err = -err;
              n_cmp++;
              if (err > 6.0) begin
                n_bad++;
                $display("FAIL sweep_err x=%0d: got %0d, expected within 6 of %f", e.x, out_y, ideal);
              end
              if (have_prev) begin
                n_cmp++;
                if (int'(out_y) < prev_sw) begin
                  n_bad++;
                  $display("FAIL sweep_mono x=%0d: got %0d, expected >= %0d", e.x, out_y, prev_sw);
                end
              end
              have_prev         = 1'b1;
              prev_sw           = int'(out_y);
              sw_y[e.x + SW]    = int'(out_y);
            end else begin
              chk($sformatf("y_tag%0d", e.tag), int'(out_y), e.y);
            end
          end
        end
        pst = out_valid && !out_ready;
        py  = out_y;
        pt  = out_tag;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : main
    int acc;
    int prev;
    for (int i = 0; i <= 2 * SW; i++) sw_y[i] = -9999;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #2;
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_out_y", int'(out_y), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Isolated samples, exact latency
    for (int i = 0; i < 8; i++) begin
      send(vx[i], vm[i], i, vy[i], 1'b1, 1'b0, acc);
      repeat (4) @(negedge clk);
    end
    drain("single");

    // Back-to-back, alternating mode, tags 0..15
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      send(vx[i], vm[i], i, vy[i], 1'b1, 1'b0, acc);
      if (i > 0) chk("stream_gap", acc - prev, 1);
      prev = acc;
    end
    drain("stream");

    // Backpressure: three beats fill the pipe, then in_ready stays low
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(vx[8 + i], vm[8 + i], 8 + i, vy[8 + i], 1'b0, 1'b0, acc);
      if (i > 0) chk("fill_gap", acc - prev, 1);
      prev = acc;
    end
    fork
      begin
        send(vx[11], vm[11], 11, vy[11], 1'b0, 1'b0, acc);
        send(vx[12], vm[12], 12, vy[12], 1'b0, 1'b0, acc);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("stall_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset while stalled with three samples in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(vx[i], vm[i], 1 + i, vy[i], 1'b0, 1'b0, acc);
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    #2;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_out_y", int'(out_y), 0);
    chk("rst_mid_out_tag", int'(out_tag), 0);
    chk("rst_mid_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #2;
      chk("post_rst_idle", int'(out_valid), 0);
    end
    chk("post_rst_y", int'(out_y), 0);
    send(vx[2], vm[2], 7, vy[2], 1'b1, 1'b0, acc);
    drain("reset");

    // Sigmoid sweep across and beyond the saturation points
    for (int x = -SW; x <= SW; x++) begin
      send(x, 1'b0, x & 15, 0, 1'b0, 1'b1, acc);
    end
    drain("sweep");
    for (int x = 1; x <= SW; x++) begin
      chk($sformatf("sym_x%0d", x), sw_y[SW + x] + sw_y[SW - x], 256);
    end
    chk("sym_x0", sw_y[SW], 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
